// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared widths, reset defaults and the FIFO entry layout
// used by the instruction fetch queue.
package fetch_queue_pkg;

    localparam int unsigned         INST_W           = 32;
    localparam int unsigned         ADDR_W           = 32;
    localparam logic [INST_W-1:0]   NOP_INST         = 32'h0;
    localparam logic [ADDR_W-1:0]   DEFAULT_RESET_PC = 32'h0000_0000;

    // One prefetch FIFO entry: fetched instruction and its pc + 4.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc_4;
    } fq_entry_t;

    localparam int unsigned ENTRY_W = $bits(fq_entry_t);

    // Force an address onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the fetch queue's instruction-memory and decode
// handshakes.
//   imem_req_*  : fetch request (valid/ready/addr), queue -> memory
//   imem_resp_* : in-order instruction return, memory -> queue
//   redirect*   : control-flow change from the hazard unit
//   id_*        : head instruction towards the IF/ID register
// master = fetch queue side, slave = memory / decode / hazard side.
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_valid;
    logic              id_ready;
    logic [INST_W-1:0] id_inst;
    logic [ADDR_W-1:0] id_pc_4;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc_4,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc_4,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// fq_fifo: synchronous FIFO with flush.
//   clk, rst_n           : clock, synchronous active-low reset
//   flush                : drop all contents (wins over push/pop)
//   push, push_data      : write at tail (accepted when not full, or full with pop)
//   pop, pop_data        : read head (pop_data is the current head entry)
//   full, empty, count   : occupancy status
module fq_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between instruction memory and the
// IF/ID register.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fetch_queue_if.master (memory request/response, redirect,
//                decode-side id_valid/id_ready/id_inst/id_pc_4)
// A request is only issued when FIFO occupancy plus outstanding requests
// leaves room, so every response always has a slot. After a redirect, the
// responses of requests still in flight are counted off and discarded.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.master bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;     // address of the oldest unanswered live request
    cnt_t              outstanding;
    cnt_t              drop;
    cnt_t              fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    fq_entry_t         push_entry;
    fq_entry_t         head;
    logic [CNT_W:0]    inflight;
    logic              req_fire;
    logic              resp_take;
    logic              resp_drop;

    assign inflight  = {1'b0, fifo_count} + {1'b0, outstanding};
    assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    assign resp_take = bus.imem_resp_valid && (drop == '0) && !bus.redirect;
    assign resp_drop = bus.imem_resp_valid && (drop != '0) && !bus.redirect;

    assign bus.imem_req_valid = rst_n && !bus.redirect && (inflight < (CNT_W + 1)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc;

    assign bus.id_valid = rst_n && !fifo_empty;
    assign bus.id_inst  = bus.id_valid ? head.inst : NOP_INST;
    assign bus.id_pc_4  = bus.id_valid ? head.pc_4 : '0;

    assign push_entry = '{inst: bus.imem_resp_data, pc_4: resp_pc + 32'd4};
    assign fifo_pop   = bus.id_valid && bus.id_ready;
    assign fifo_push  = resp_take && (!fifo_full || fifo_pop);

    // Redirect drives flush, which overrides any push/pop in the same cycle.
    fq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.redirect),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= align_word(RESET_PC);
            resp_pc     <= align_word(RESET_PC);
            outstanding <= '0;
            drop        <= '0;
        end else begin
            case ({req_fire, bus.imem_resp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (bus.redirect) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= align_word(bus.redirect_pc);
                resp_pc  <= align_word(bus.redirect_pc);
                drop     <= outstanding - cnt_t'(bus.imem_resp_valid);
            end else begin
                if (req_fire)  fetch_pc <= fetch_pc + 32'd4;
                if (resp_take) resp_pc  <= resp_pc + 32'd4;
                if (resp_drop) drop     <= drop - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue (DEPTH=4, RESET_PC=0).
// A fixed-latency memory model answers requests in order; every issued
// request pushes its expected {inst, pc+4} onto a scoreboard which is
// checked as the head pops, and cleared on redirect.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } mem_t;

    typedef struct {
        logic        rstn;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_idv;
        logic [31:0] exp_pc4;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fetch_queue_if bus ();

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    mem_t        mem_q[$];
    int unsigned lat = 1;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_fetch = 32'h0;
    int          m_occ = 0;
    int          m_drop = 0;
    int          req_cnt = 0;

    logic        o_rv, o_idv, o_resp;
    logic [31:0] o_addr, o_pc4, o_inst;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, run the memory model,
    // sample DUT outputs, check against the scoreboard and update the model.
    task automatic tick(input logic rstn, input logic rdy, input logic redir, input logic [31:0] rpc);
        int m_out;
        logic pop;
        @(negedge clk);
        rst_n           = rstn;
        bus.id_ready    = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.imem_req_ready = 1'b1;
        if (!rstn) mem_q.delete();
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_q[0].data;
            void'(mem_q.pop_front());
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
        end
        #1;
        o_rv   = bus.imem_req_valid;
        o_addr = bus.imem_req_addr;
        o_idv  = bus.id_valid;
        o_inst = bus.id_inst;
        o_pc4  = bus.id_pc_4;
        o_resp = bus.imem_resp_valid;
        if (!rstn) begin
            chk("rst_req_valid", {31'b0, o_rv}, 32'h0);
            chk("rst_id_valid", {31'b0, o_idv}, 32'h0);
            chk("rst_id_inst", o_inst, 32'h0);
            chk("rst_id_pc_4", o_pc4, 32'h0);
            exp_q.delete();
            m_occ = 0;
            m_drop = 0;
            exp_fetch = 32'h0;
        end else begin
            m_out = mem_q.size() + (o_resp ? 1 : 0);
            chk("req_valid", {31'b0, o_rv}, {31'b0, (!redir && (m_occ + m_out < DEPTH))});
            chk("id_valid", {31'b0, o_idv}, {31'b0, (m_occ > 0)});
            if (o_idv) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_entry: got pc_4 %h expected no entry", o_pc4);
                end else begin
                    chk("id_inst", o_inst, exp_q[0].inst);
                    chk("id_pc_4", o_pc4, exp_q[0].pc4);
                end
            end
            pop = (m_occ > 0) && rdy;
            if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
            if (o_rv) begin
                chk("req_addr", o_addr, exp_fetch);
                mem_q.push_back('{inst_of(o_addr), cyc + lat});
                exp_q.push_back('{inst_of(o_addr), o_addr + 32'd4});
                exp_fetch = exp_fetch + 32'd4;
                req_cnt++;
            end
            if (redir) begin
                exp_q.delete();
                exp_fetch = {rpc[31:2], 2'b00};
                m_occ = 0;
                m_drop = m_out - (o_resp ? 1 : 0);
            end else begin
                if (o_resp) begin
                    if (m_drop > 0) m_drop--;
                    else m_occ++;
                end
                if (pop) m_occ--;
            end
        end
        cyc++;
    endtask

    task automatic do_reset(input int unsigned new_lat);
        lat = new_lat;
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic wait_idv(input string name, input int bound);
        int n = 0;
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        while (!o_idv && n < bound) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            n++;
        end
        if (!o_idv) begin
            checks++;
            errors++;
            $display("FAIL %s: id_valid not seen within %0d cycles", name, bound);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   r0;

        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.redirect        = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.id_ready        = 1'b1;

        // Reset, then streaming with a 1-cycle memory.
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,  1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4,  1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8,  1'b1, 32'h4};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hC,  1'b1, 32'h8};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'hC};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h14, 1'b1, 32'h10};

        lat = 1;
        for (int i = 0; i < 8; i++) begin
            tick(vecs[i].rstn, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
            chk($sformatf("vec%0d_req_valid", i), {31'b0, o_rv}, {31'b0, vecs[i].exp_rv});
            if (vecs[i].exp_rv) chk($sformatf("vec%0d_req_addr", i), o_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_id_valid", i), {31'b0, o_idv}, {31'b0, vecs[i].exp_idv});
            chk($sformatf("vec%0d_id_pc_4", i), o_pc4, vecs[i].exp_pc4);
        end

        // Decode stalled for 10 cycles: exactly DEPTH requests, then nothing.
        do_reset(1);
        r0 = req_cnt;
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("stall_req_count", req_cnt - r0, DEPTH);
        chk("stall_req_valid_low", {31'b0, o_rv}, 32'h0);
        chk("stall_head_pc_4", o_pc4, 32'h4);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);

        // 3-cycle memory, redirect to 0x100 with three requests in flight.
        do_reset(3);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h100);
        wait_idv("redir_first_valid", 20);
        chk("redir_first_pc_4", o_pc4, 32'h104);
        chk("redir_first_inst", o_inst, inst_of(32'h100));
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect coincident with a response and a pop.
        do_reset(1);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h200);
        chk("coinc_resp_present", {31'b0, o_resp}, 32'h1);
        chk("coinc_pop_present", {31'b0, o_idv}, 32'h1);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("coinc_id_valid_next", {31'b0, o_idv}, 32'h0);
        wait_idv("coinc_first_valid", 10);
        chk("coinc_first_pc_4", o_pc4, 32'h204);

        // Redirect to a misaligned top-of-memory address: fetch wraps.
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_addr0", o_addr, 32'hFFFF_FFFC);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_addr1", o_addr, 32'h0000_0000);
        wait_idv("wrap_first_valid", 10);
        chk("wrap_pc_4_0", o_pc4, 32'h0000_0000);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_pc_4_1", o_pc4, 32'h0000_0004);

        // Reset mid-stream with two requests outstanding.
        do_reset(3);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("mid_rst_req_valid", {31'b0, o_rv}, 32'h1);
        chk("mid_rst_req_addr", o_addr, 32'h0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);

        // Random decode stalls and redirects against the scoreboard.
        lat = 2;
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                 {$urandom_range(0, 255), 2'b00} | 32'h0000_1000);
        end
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning prefetch FIFO entries and maximum outstanding requests; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 imem_req_valid  output  1  fetch request present.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_req_addr  output  32  word-aligned fetch address; bits [1:0] always 00.
REQ-008 imem_resp_valid  input  1  in-order instruction return; always accepted, no back-pressure.
REQ-009 imem_resp_data  input  32  returned instruction word.
REQ-010 redirect  input  1  control-flow change from the hazard unit (taken branch, j/jal, jr).
REQ-011 redirect_pc  input  32  new fetch address; bits [1:0] ignored.
REQ-012 id_valid  output  1  id_inst/id_pc_4 hold a valid instruction for the IF/ID register.
REQ-013 id_ready  input  1  IF/ID register accepts (deasserted on stall).
REQ-014 id_inst  output  32  head instruction.
REQ-015 id_pc_4  output  32  head instruction address + 4.

Function
REQ-016 fetch_pc register SHALL drive imem_req_addr; it advances by 4 on each request handshake (imem_req_valid & imem_req_ready) and wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-017 imem_req_valid SHALL be high iff occupancy + outstanding < DEPTH and redirect is low; a request is never issued that could overflow the FIFO.
REQ-018 outstanding counter SHALL increment on request handshake, decrement on imem_resp_valid, both in one cycle leaving it unchanged; width clog2(DEPTH+1).
REQ-019 Each FIFO entry SHALL store {instruction, pc+4}; the pc of a response equals the address of the oldest unanswered request (tracked in a DEPTH-deep address shadow or derived from a response pc register).
REQ-020 A non-discarded response SHALL be written to the FIFO tail on its arrival cycle; id_valid for that entry rises the following cycle (1-cycle fill latency).
REQ-021 id_valid SHALL equal FIFO non-empty; head pops on id_valid & id_ready; push and pop in the same cycle keep occupancy unchanged, including when full.
REQ-022 With id_ready low, id_valid/id_inst/id_pc_4 SHALL hold stable.
REQ-023 On redirect: FIFO cleared, fetch_pc <= {redirect_pc[31:2],2'b00}, drop counter <= outstanding minus any response arriving that cycle; id_valid low next cycle.
REQ-024 While drop counter > 0, each imem_resp_valid SHALL decrement it and the data SHALL be discarded (not written).
REQ-025 Redirect coincident with pop: redirect wins; popped entry is consumed, rest cleared. Redirect coincident with response: response discarded.
REQ-026 Back-to-back redirects SHALL be handled; each recomputes drop counter from total outstanding.
REQ-027 Sustained throughput with a single-cycle memory and id_ready high SHALL be one instruction per cycle.

Reset
REQ-028 During rst_n low: fetch_pc = RESET_PC, occupancy = 0, outstanding = 0, drop = 0, imem_req_valid = 0, id_valid = 0, id_inst = 32'h0, id_pc_4 = 32'h0.
REQ-029 First request SHALL be presented the cycle after rst_n rises; responses arriving during reset are ignored and outstanding restarts at 0 (memory is reset in the same domain).

Structure
REQ-030 Shared package SHALL hold INST_W = 32, ADDR_W = 32, NOP_INST = 32'h0, default RESET_PC.
REQ-031 One sub-module fq_fifo (synchronous FIFO, parameterised width/depth, flush input, full/empty/count outputs); pointer and counter logic live only there.

Verification
REQ-032 Reset then 1-cycle memory, id_ready=1: requests 0x0,0x4,0x8...; id_pc_4 sequence 0x4,0x8,0xC at one per cycle after fill.
REQ-033 DEPTH=4, id_ready=0 for 10 cycles: exactly 4 requests issued, imem_req_valid low thereafter, no lost instructions after id_ready returns.
REQ-034 3-cycle memory, 3 outstanding, redirect to 0x100: next 3 responses dropped, first id_valid shows id_pc_4 = 0x104.
REQ-035 redirect, imem_resp_valid and id_valid&id_ready in same cycle: next cycle id_valid=0, response absent from FIFO.
REQ-036 redirect_pc = 0xFFFF_FFFE: requests 0xFFFF_FFFC then 0x0000_0000; id_pc_4 = 0x0000_0000 then 0x0000_0004.
REQ-037 rst_n low mid-stream with 2 outstanding: all outputs at reset values next cycle; fetch restarts at RESET_PC.
